// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states and
// the sizing rule for the POW iteration counter.
package seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_POW = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_NOR = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Counter must hold both a WIDTH-step loop count and any b value for POW.
   function automatic int cnt_width(input int width);
      int w_c;
      w_c = $clog2(width + 1);
      return (width > w_c) ? width : w_c;
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU: request handshake with
// operands and opcode, response handshake with result and status flags.
interface seq_alu_if
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
);
   localparam int RW = 2 * WIDTH;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_t              sel;
   logic             out_valid;
   logic             out_ready;
   logic [RW-1:0]    result;
   logic             flag_zero;
   logic             flag_carry;
   logic             flag_ovf;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
   );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: bit 0 is folded in on i_start, then one
// multiplier bit per cycle; o_done flags the cycle whose step is the last.
module seq_alu_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product
);
   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   logic          r_busy;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [RW-1:0] r_acc;
   logic [RW-1:0] w_acc_nx;

   assign w_acc_nx  = r_acc + (r_mplier[0] ? r_mcand : {RW{1'b0}});
   assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));
   assign o_product = w_acc_nx;

   // Partial-product accumulation, one multiplier bit per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= {CW{1'b0}};
         r_mcand  <= {RW{1'b0}};
         r_mplier <= {WIDTH{1'b0}};
         r_acc    <= {RW{1'b0}};
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= CW'(1);
         r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
         r_mplier <= i_b >> 1;
         r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : {RW{1'b0}};
      end else if (r_busy) begin
         r_busy   <= !o_done;
         r_cnt    <= r_cnt + CW'(1);
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_acc    <= w_acc_nx;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU slave: single-cycle add/sub/logic, iterative MUL and POW,
// results and flags held in DONE until the consumer takes them.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic     clk,
   input logic     rst,
   seq_alu_if.slave bus
);
   localparam int RW = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);
   localparam int PW = RW + WIDTH;

   state_t           r_state, w_state_nx;
   op_t              r_sel, w_sel_nx;
   logic [WIDTH-1:0] r_a, w_a_nx;
   logic [RW-1:0]    r_acc, w_acc_nx;
   logic [CW-1:0]    r_cnt, w_cnt_nx;
   logic [RW-1:0]    r_result, w_result_nx;
   logic             r_zero, w_zero_nx;
   logic             r_carry, w_carry_nx;
   logic             r_ovf, w_ovf_nx;
   logic             w_finish;
   logic             w_accept;
   logic [RW-1:0]    w_a_ext, w_b_ext, w_sum, w_diff;
   logic [PW-1:0]    w_pow_full;
   logic             w_mul_done;
   logic [RW-1:0]    w_mul_product;

   assign w_accept   = bus.in_valid && bus.in_ready;
   assign w_a_ext    = {{WIDTH{1'b0}}, bus.a};
   assign w_b_ext    = {{WIDTH{1'b0}}, bus.b};
   assign w_sum      = w_a_ext + w_b_ext;
   assign w_diff     = w_a_ext - w_b_ext;
   assign w_pow_full = PW'(r_acc) * PW'(r_a);

   seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_accept && (bus.sel == OP_MUL)),
      .i_a       (bus.a),
      .i_b       (bus.b),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // Next-state and datapath updates for IDLE/BUSY/DONE.
   always_comb begin
      w_state_nx  = r_state;
      w_sel_nx    = r_sel;
      w_a_nx      = r_a;
      w_acc_nx    = r_acc;
      w_cnt_nx    = r_cnt;
      w_result_nx = r_result;
      w_zero_nx   = r_zero;
      w_carry_nx  = r_carry;
      w_ovf_nx    = r_ovf;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_sel_nx   = bus.sel;
               w_a_nx     = bus.a;
               w_carry_nx = 1'b0;
               w_ovf_nx   = 1'b0;
               case (bus.sel)
                  OP_ADD: begin
                     w_result_nx = w_sum;
                     w_carry_nx  = w_sum[WIDTH];
                     w_finish    = 1'b1;
                  end
                  OP_SUB: begin
                     w_result_nx = w_diff;
                     w_carry_nx  = (bus.a < bus.b);
                     w_finish    = 1'b1;
                  end
                  OP_MUL: w_state_nx = ST_BUSY;
                  OP_POW: begin
                     // The accept edge already performs the first multiply by a.
                     if (bus.b == {WIDTH{1'b0}}) begin
                        w_result_nx = RW'(1);
                        w_finish    = 1'b1;
                     end else if (bus.b == WIDTH'(1)) begin
                        w_result_nx = w_a_ext;
                        w_finish    = 1'b1;
                     end else begin
                        w_acc_nx   = w_a_ext;
                        w_cnt_nx   = CW'(bus.b) - CW'(1);
                        w_state_nx = ST_BUSY;
                     end
                  end
                  OP_AND: begin
                     w_result_nx = {{WIDTH{1'b0}}, bus.a & bus.b};
                     w_finish    = 1'b1;
                  end
                  OP_OR: begin
                     w_result_nx = {{WIDTH{1'b0}}, bus.a | bus.b};
                     w_finish    = 1'b1;
                  end
                  OP_XOR: begin
                     w_result_nx = {{WIDTH{1'b0}}, bus.a ^ bus.b};
                     w_finish    = 1'b1;
                  end
                  OP_NOR: begin
                     w_result_nx = {{WIDTH{1'b0}}, ~(bus.a | bus.b)};
                     w_finish    = 1'b1;
                  end
                  default: begin
                     w_result_nx = {RW{1'b0}};
                     w_finish    = 1'b1;
                  end
               endcase
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (r_sel == OP_MUL) begin
               if (w_mul_done) begin
                  w_result_nx = w_mul_product;
                  w_finish    = 1'b1;
               end else begin
                  w_state_nx = ST_BUSY;
               end
            end else begin
               w_acc_nx = w_pow_full[RW-1:0];
               w_ovf_nx = r_ovf | (|w_pow_full[PW-1:RW]);
               w_cnt_nx = r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  w_result_nx = w_pow_full[RW-1:0];
                  w_finish    = 1'b1;
               end else begin
                  w_state_nx = ST_BUSY;
               end
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nx = ST_IDLE;
            end else begin
               w_state_nx = ST_DONE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
      if (w_finish) begin
         w_state_nx = ST_DONE;
         w_zero_nx  = (w_result_nx == {RW{1'b0}});
      end else begin
         w_zero_nx = r_zero;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_sel    <= OP_ADD;
         r_a      <= {WIDTH{1'b0}};
         r_acc    <= {RW{1'b0}};
         r_cnt    <= {CW{1'b0}};
         r_result <= {RW{1'b0}};
         r_zero   <= 1'b0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_sel    <= w_sel_nx;
         r_a      <= w_a_nx;
         r_acc    <= w_acc_nx;
         r_cnt    <= w_cnt_nx;
         r_result <= w_result_nx;
         r_zero   <= w_zero_nx;
         r_carry  <= w_carry_nx;
         r_ovf    <= w_ovf_nx;
      end
   end

   assign bus.in_ready   = (r_state == ST_IDLE) && !rst;
   assign bus.out_valid  = (r_state == ST_DONE);
   assign bus.result     = r_result;
   assign bus.flag_zero  = r_zero;
   assign bus.flag_carry = r_carry;
   assign bus.flag_ovf   = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): hand-computed results, flags and
// handshake timing, backpressure and reset abort.
module tb_seq_alu;
   import seq_alu_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   seq_alu_if #(.WIDTH(8)) bus ();

   seq_alu #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request and verify out_valid appears exactly lat cycles later.
   task automatic run_op(input string tag, input op_t op, input logic [7:0] a,
                         input logic [7:0] b, input int lat);
      chk({tag, ".in_ready_pre"}, bus.in_ready, 1);
      bus.sel      = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = 8'hA5;
      bus.b        = 8'h5A;
      bus.sel      = OP_ADD;
      for (int i = 1; i < lat; i++) begin
         chk({tag, ".out_valid_early"}, bus.out_valid, 0);
         chk({tag, ".in_ready_busy"}, bus.in_ready, 0);
         tick();
      end
      chk({tag, ".out_valid"}, bus.out_valid, 1);
   endtask

   task automatic chk_res(input string tag, input logic [15:0] res, input logic z,
                          input logic c, input logic o);
      chk({tag, ".result"}, bus.result, {16'd0, res});
      chk({tag, ".zero"}, bus.flag_zero, {31'd0, z});
      chk({tag, ".carry"}, bus.flag_carry, {31'd0, c});
      chk({tag, ".ovf"}, bus.flag_ovf, {31'd0, o});
   endtask

   task automatic consume(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, ".out_valid_after"}, bus.out_valid, 0);
      chk({tag, ".in_ready_after"}, bus.in_ready, 1);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = 8'd0;
      bus.b         = 8'd0;
      bus.sel       = OP_ADD;
      tick();
      tick();
      chk("reset.in_ready", bus.in_ready, 0);
      chk("reset.out_valid", bus.out_valid, 0);
      chk_res("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("reset.in_ready_release", bus.in_ready, 1);

      run_op("add", OP_ADD, 8'd200, 8'd100, 1);
      chk_res("add", 16'h012C, 1'b0, 1'b1, 1'b0);
      consume("add");

      run_op("sub_neg", OP_SUB, 8'd3, 8'd5, 1);
      chk_res("sub_neg", 16'hFFFE, 1'b0, 1'b1, 1'b0);
      consume("sub_neg");

      run_op("sub_eq", OP_SUB, 8'd9, 8'd9, 1);
      chk_res("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b0);
      consume("sub_eq");

      run_op("mul", OP_MUL, 8'd255, 8'd255, 8);
      chk_res("mul", 16'hFE01, 1'b0, 1'b0, 1'b0);
      consume("mul");

      run_op("mul_small", OP_MUL, 8'd12, 8'd13, 8);
      chk_res("mul_small", 16'd156, 1'b0, 1'b0, 1'b0);
      consume("mul_small");

      run_op("pow_3_5", OP_POW, 8'd3, 8'd5, 5);
      chk_res("pow_3_5", 16'd243, 1'b0, 1'b0, 1'b0);
      consume("pow_3_5");

      run_op("pow_7_0", OP_POW, 8'd7, 8'd0, 1);
      chk_res("pow_7_0", 16'd1, 1'b0, 1'b0, 1'b0);
      consume("pow_7_0");

      run_op("pow_16_5", OP_POW, 8'd16, 8'd5, 5);
      chk_res("pow_16_5", 16'd0, 1'b1, 1'b0, 1'b1);
      consume("pow_16_5");

      run_op("pow_0_3", OP_POW, 8'd0, 8'd3, 3);
      chk_res("pow_0_3", 16'd0, 1'b1, 1'b0, 1'b0);
      consume("pow_0_3");

      run_op("and", OP_AND, 8'hF0, 8'h3C, 1);
      chk_res("and", 16'h0030, 1'b0, 1'b0, 1'b0);
      consume("and");

      run_op("xor", OP_XOR, 8'hFF, 8'hFF, 1);
      chk_res("xor", 16'h0000, 1'b1, 1'b0, 1'b0);
      consume("xor");

      run_op("nor", OP_NOR, 8'h0F, 8'h30, 1);
      chk_res("nor", 16'h00C0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold.out_valid", bus.out_valid, 1);
         chk("hold.in_ready", bus.in_ready, 0);
         chk("hold.result", bus.result, 32'h0000_00C0);
      end
      consume("nor");

      // MUL aborted by a one-cycle reset at T+3.
      chk("abort.in_ready_pre", bus.in_ready, 1);
      bus.sel      = OP_MUL;
      bus.a        = 8'd12;
      bus.b        = 8'd13;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("abort.in_ready_in_rst", bus.in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("abort.in_ready_post", bus.in_ready, 1);
      for (int i = 0; i < 10; i++) begin
         chk("abort.no_out_valid", bus.out_valid, 0);
         tick();
      end
      run_op("add_after_abort", OP_ADD, 8'd1, 8'd1, 1);
      chk_res("add_after_abort", 16'd2, 1'b0, 1'b0, 1'b0);
      consume("add_after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
